// File: rtl/midi_tx_arb.sv
// midi_tx_arb: round-robin arbiter feeding a single 31250-baud MIDI serialiser.
// Sources present whole messages (up to MAX_BYTES bytes); the granted message
// is latched at the accept edge and sent byte 0 first, with optional
// running-status compression of repeated channel status bytes.
//
// Handshake: midi_data_rdy[s] is a level "valid". When IDLE, the block grants
// one ready source per accept edge and answers with a one-cycle
// midi_data_rd[s] pulse registered at that edge. That pulse is the "ready".
// The source must drop rdy, or present its next message, in the cycle the
// pulse is visible. No grant is made in that cycle, so a discarded
// zero-length message cannot be re-granted before its source has reacted.
module midi_tx_arb #(
  parameter int NUM_SRC        = 4,
  parameter int MAX_BYTES      = 4,
  parameter int CLKS_PER_BIT   = 4,
  parameter int RUNNING_STATUS = 1,
  parameter int LW             = $clog2(MAX_BYTES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC*MAX_BYTES*8-1:0] midi_data,
  input  logic [NUM_SRC*LW-1:0]          midi_len,
  input  logic [NUM_SRC-1:0]             midi_data_rdy,
  output logic [NUM_SRC-1:0]             midi_data_rd,
  output logic                           midi_tx,
  output logic                           busy,
  output logic [1:0]                     state_o
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int MW = MAX_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [MW-1:0]      buf_q, buf_d;
  logic [BW-1:0]      byte_q, byte_d;
  logic [BW-1:0]      last_q, last_d;
  logic [2:0]         bit_q, bit_d;
  logic [CW-1:0]      baud_q, baud_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC-1:0] rd_q, rd_d;
  logic [7:0]         rs_q, rs_d;
  logic               rs_v_q, rs_v_d;

  logic               grant_v;
  logic [SW-1:0]      grant_s;
  logic [MW-1:0]      sel_data;
  int                 sel_len;
  int                 first_idx;
  logic               skip;
  logic [7:0]         first_byte;
  logic [7:0]         cur_byte;
  logic [7:0]         nxt_byte;
  logic               baud_end;

  // Running-status register update for one byte that goes onto the line.
  function automatic logic [8:0] rs_upd(input logic [7:0] b, input logic [7:0] rs,
                                        input logic rv);
    if (b >= 8'h80 && b <= 8'hEF) return {1'b1, b};
    else if (b >= 8'hF0 && b <= 8'hF7) return {1'b0, rs};
    else return {rv, rs};
  endfunction

  // Round-robin search: first ready source at or above ptr, wrapping around.
  always_comb begin
    grant_v = 1'b0;
    grant_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_v && midi_data_rdy[(int'(ptr_q) + i) % NUM_SRC]) begin
        grant_v = 1'b1;
        grant_s = SW'((int'(ptr_q) + i) % NUM_SRC);
      end
    end
  end

  // Granted message: clamp length and decide whether its status byte is redundant.
  always_comb begin
    sel_data = midi_data[int'(grant_s)*MW +: MW];
    sel_len  = int'(midi_len[int'(grant_s)*LW +: LW]);
    if (sel_len > MAX_BYTES) sel_len = MAX_BYTES;
    skip = (RUNNING_STATUS != 0) && (sel_len >= 2) &&
           (sel_data[7:0] >= 8'h80) && (sel_data[7:0] <= 8'hEF) &&
           rs_v_q && (sel_data[7:0] == rs_q);
    first_idx  = skip ? 1 : 0;
    first_byte = sel_data[first_idx*8 +: 8];
  end

  // Byte currently on the line, the one after it, and end-of-bit strobe.
  always_comb begin
    cur_byte = buf_q[int'(byte_q)*8 +: 8];
    nxt_byte = buf_q[((int'(byte_q) + 1) % MAX_BYTES)*8 +: 8];
    baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));
  end

  // Next-state logic: arbitration in IDLE, then start/data/stop bit timing.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    buf_d   = buf_q;
    byte_d  = byte_q;
    last_d  = last_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    rd_d    = '0;
    rs_d    = rs_q;
    rs_v_d  = rs_v_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (grant_v && (rd_q == '0)) begin
          rd_d[grant_s] = 1'b1;
          ptr_d = SW'((int'(grant_s) + 1) % NUM_SRC);
          if (sel_len != 0) begin
            state_d = START;
            buf_d   = sel_data;
            byte_d  = BW'(first_idx);
            last_d  = BW'(sel_len - 1);
            bit_d   = '0;
            baud_d  = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            {rs_v_d, rs_d} = rs_upd(first_byte, rs_q, rs_v_q);
          end
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == last_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = START;
            tx_d    = 1'b0;
            {rs_v_d, rs_d} = rs_upd(nxt_byte, rs_q, rs_v_q);
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any frame and returns the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      buf_q   <= '0;
      byte_q  <= '0;
      last_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_q    <= '0;
      rs_q    <= '0;
      rs_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rs_v_q  <= rs_v_d;
    end
  end

  assign midi_data_rd = rd_q;
  assign midi_tx      = tx_q;
  assign busy         = busy_q;
  assign state_o      = state_q;

endmodule

// File: doc/midi_tx_arb.md
# midi_tx_arb

Parametrised MIDI transmitter that serialises up to MAX_BYTES-byte messages from NUM_SRC independent sources onto one MIDI output line. Sources are granted in round-robin order, and optional running-status compression drops repeated channel status bytes. The block runs from the 125 kHz sample clock, with CLKS_PER_BIT clocks per 31250-baud bit. It replaces the single-source, fixed-format midi_tx on the router output side.

## Interface
- NUM_SRC, 4: number of message sources, 1..8.
- MAX_BYTES, 4: maximum bytes per message, 1..4.
- CLKS_PER_BIT, 4: clocks per serial bit, ≥1.
- RUNNING_STATUS, 1: 1 enables running-status suppression; 0 always sends every byte.
- LW, $clog2(MAX_BYTES+1): width of each length field.

- clk  in  1  sample clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- midi_data  in  NUM_SRC*MAX_BYTES*8  flattened message bytes. Source s, byte b is at bits [(s*MAX_BYTES+b)*8 +: 8]. Byte 0 is sent first.
- midi_len  in  NUM_SRC*LW  byte count for source s, at [s*LW +: LW].
- midi_data_rdy  in  NUM_SRC  level; source s holds a valid message.
- midi_data_rd  out  NUM_SRC  one-cycle accept pulse per source.
- midi_tx  out  1  serial line; idle high.
- busy  out  1  high while a message is being serialised.

## Operation
- **Frame format:** start bit (0), then 8 data bits LSB first, then stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- **FSM states:** IDLE, START, DATA, STOP. A bit counter runs 0..7, a byte index runs 0..MAX_BYTES-1, and a baud counter runs 0..CLKS_PER_BIT-1.
- **Arbitration in IDLE:** at each edge, the block picks the first asserted midi_data_rdy, searching from source ptr upward with wrap. At that edge it:
  - latches that source's bytes and length;
  - sets midi_data_rd[s]=1 for exactly one cycle;
  - sets ptr = s+1 mod NUM_SRC.
- **Source obligation:** the source must drop midi_data_rdy, or present its next message, within 1 cycle of midi_data_rd.
- **Length rules:**
  - len=0: the message is accepted (rd pulse) and discarded. No line activity, and busy stays low.
  - len>MAX_BYTES: clamped to MAX_BYTES.
- **Running status (RUNNING_STATUS=1):** a register rs holds the last sent status byte, with valid flag rs_v.
  - If len≥2, byte0 is in 0x80–0xEF, rs_v=1, and byte0==rs, then byte0 is skipped and transmission starts at byte1.
  - A sent byte in 0x80–0xEF sets rs=byte and rs_v=1.
  - A sent byte in 0xF0–0xF7 clears rs_v.
  - Bytes in 0xF8–0xFF and data bytes (<0x80) leave rs unchanged.
- **Progress:** after the STOP bit of the last byte the FSM returns to IDLE; otherwise it goes to START of the next byte.
- **Reset values:** midi_tx=1, midi_data_rd=0, busy=0, state=IDLE, ptr=0, rs_v=0.
- **Reset mid-frame:** the frame is aborted and the line returns high the cycle after rst is sampled. No rd pulse is issued during rst.

## Timing
- **Accept edge (k):** midi_tx=0 and busy=1 from edge k, for every message with a nonzero transmitted byte count.
- **Message duration:** for n transmitted bytes, the line is driven for n*10*CLKS_PER_BIT cycles from edge k. busy deasserts at edge k + n*10*CLKS_PER_BIT.
- **Frame spacing:** the FSM spends at least 1 cycle in IDLE between messages. The earliest next start bit is 1 cycle after busy falls, so the stop-plus-idle gap is CLKS_PER_BIT+1 cycles.
- **Bytes within a message:** no gap between stop and the next start bit.
- **Input sampling:** midi_data and midi_len are sampled only at the accept edge. Changes while busy have no effect.
- **Simultaneous requests:** exactly one grant per IDLE cycle. A source requesting at the same edge as its ptr turn wins.

## Test plan
- **Single byte:** src0 sends 0x01, len=1, CLKS_PER_BIT=4.
  - midi_tx bits are 0,1,0,0,0,0,0,0,0,1, each held 4 clocks.
  - One midi_data_rd[0] pulse; busy high for 40 cycles, then the line stays high.
- **Round robin:** all 4 sources assert rdy with 1-byte messages 0xA0..0xA3 and re-assert after each rd.
  - Grant order is 0,1,2,3,0.
  - Each frame start is 41 cycles after the previous one.
- **Running status:** src0 sends 90 3C 40, then 90 3C 00.
  - The second message is sent as 3C 00 only (80 cycles).
  - Insert F8 (len 1) between the two: the second message is still compressed.
  - Insert F6 instead: the second message is sent in full (120 cycles).
  - With RUNNING_STATUS=0, every message is sent in full.
- **Length edges:**
  - len=0: rd pulse, no line activity, busy stays low.
  - len=7 with MAX_BYTES=4: 4 bytes sent.
- **Reset mid-frame:** assert rst during bit 3 of the second byte.
  - Next cycle: midi_tx=1, busy=0.
  - After release, the next grant starts at src0 and the first message is not compressed.
- **CLKS_PER_BIT=1, NUM_SRC=1:** a 3-byte message completes in 30 cycles with correct bit order.
